pc_btb_unit: RTL and testbench

Parametrised program-counter unit for the pipelined core. It combines the PC register, the +4 incrementer and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Each cycle it produces the fetch PC and a predicted next PC. Stall comes from the hazard detection unit; redirect and BTB training come from the execute stage on branch/jump resolution.

---
 rtl/pc_btb_unit_if.sv | 29 ++
 rtl/pc_btb_unit.sv | 105 ++++++++++
 tb/tb_pc_btb_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pc_btb_unit_if.sv
// Signal bundle between the PC/BTB unit and the rest of the pipeline:
// stall, execute-stage redirect and training inputs, fetch/prediction outputs.
interface pc_btb_unit_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            update_valid;
    logic [XLEN-1:0] update_pc;
    logic [XLEN-1:0] update_target;
    logic            update_taken;
    logic [XLEN-1:0] current_pc;
    logic [XLEN-1:0] predicted_next_pc;
    logic            pred_hit;
    logic            pred_taken;

    modport master (
        output stall, redirect_valid, redirect_pc,
        output update_valid, update_pc, update_target, update_taken,
        input  current_pc, predicted_next_pc, pred_hit, pred_taken
    );

    modport slave (
        input  stall, redirect_valid, redirect_pc,
        input  update_valid, update_pc, update_target, update_taken,
        output current_pc, predicted_next_pc, pred_hit, pred_taken
    );
endinterface

// File: rtl/pc_btb_unit.sv
// Fetch PC register with +4 incrementer and a direct-mapped BTB of 2-bit
// saturating counters; lookup is combinational on the registered fetch PC.
module pc_btb_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int              BTB_ENTRIES = 16
) (
    input logic          clk,
    input logic          reset,
    pc_btb_unit_if.slave bus
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    logic [XLEN-1:0]  r_pc;
    logic             r_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] r_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]  r_target [BTB_ENTRIES];
    logic [1:0]       r_ctr    [BTB_ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic             w_lk_taken;
    logic [XLEN-1:0]  w_pred_next;
    logic [XLEN-1:0]  w_pc_next;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_unused;

    assign w_lk_idx    = r_pc[IDX_W+1:2];
    assign w_lk_tag    = r_pc[XLEN-1:IDX_W+2];
    assign w_lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
    assign w_pred_next = w_lk_taken ? r_target[w_lk_idx] : r_pc + PC_STEP;

    assign w_up_idx = bus.update_pc[IDX_W+1:2];
    assign w_up_tag = bus.update_pc[XLEN-1:IDX_W+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_unused = ^{r_pc[1:0], bus.update_pc[1:0]};

    // Next fetch PC: redirect beats stall, otherwise follow the prediction
    always_comb begin
        w_pc_next = r_pc;
        if (bus.redirect_valid) begin
            w_pc_next = bus.redirect_pc;
        end else if (bus.stall) begin
            w_pc_next = r_pc;
        end else begin
            w_pc_next = w_pred_next;
        end
    end

    // Fetch PC register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Valid bits and direction counters; reset leaves every entry invalid, weakly not-taken
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
        end else if (bus.update_valid) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= bus.update_taken ? sat_inc(r_ctr[w_up_idx])
                                                    : sat_dec(r_ctr[w_up_idx]);
            end else if (bus.update_taken) begin
                r_valid[w_up_idx] <= 1'b1;
                r_ctr[w_up_idx]   <= 2'b10;
            end
        end
    end

    // Tag and target payload; only meaningful while the matching valid bit is set
    always_ff @(posedge clk) begin
        if (!reset && bus.update_valid && bus.update_taken) begin
            r_target[w_up_idx] <= bus.update_target;
            if (!w_up_hit) begin
                r_tag[w_up_idx] <= w_up_tag;
            end
        end
    end

    assign bus.current_pc        = r_pc;
    assign bus.predicted_next_pc = w_pred_next;
    assign bus.pred_hit          = w_lk_hit;
    assign bus.pred_taken        = w_lk_taken;
endmodule

// File: tb/tb_pc_btb_unit.sv
// Directed bench for pc_btb_unit: the driver queues the expected outputs of
// each cycle, and a negedge monitor pops and compares them against the DUT.
module tb_pc_btb_unit;
    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic        tk;
        logic [31:0] npc;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    pc_btb_unit_if #(.XLEN(32)) bus ();

    pc_btb_unit #(
        .XLEN(32),
        .RESET_PC(32'h0000_0000),
        .BTB_ENTRIES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, compare against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp("current_pc", bus.current_pc, e.pc);
            cmp("pred_hit", {31'd0, bus.pred_hit}, {31'd0, e.hit});
            cmp("pred_taken", {31'd0, bus.pred_taken}, {31'd0, e.tk});
            cmp("predicted_next_pc", bus.predicted_next_pc, e.npc);
        end
    end

    task automatic ex(input logic [31:0] pc, input logic hit, input logic tk, input logic [31:0] npc);
        exp_t e;
        e.pc = pc; e.hit = hit; e.tk = tk; e.npc = npc;
        exp_q.push_back(e);
    endtask

    task automatic drv(input logic st, input logic rv, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] upc, input logic [31:0] utg,
                       input logic utk);
        bus.stall          = st;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.update_valid   = uv;
        bus.update_pc      = upc;
        bus.update_target  = utg;
        bus.update_taken   = utk;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle();
        tick();
        // Reset state, then free-run from 0
        ex(32'h0, 1'b0, 1'b0, 32'h4);          tick();
        ex(32'h0, 1'b0, 1'b0, 32'h4);   reset = 1'b0; tick();
        ex(32'h4, 1'b0, 1'b0, 32'h8);          tick();
        // Stall holds 0x8 for three cycles
        ex(32'h8, 1'b0, 1'b0, 32'hC);   drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0); tick();
        ex(32'h8, 1'b0, 1'b0, 32'hC);   tick();
        ex(32'h8, 1'b0, 1'b0, 32'hC);   tick();
        ex(32'h8, 1'b0, 1'b0, 32'hC);   idle(); tick();
        // Redirect wins over stall
        ex(32'hC, 1'b0, 1'b0, 32'h10);  drv(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0); tick();
        ex(32'h100, 1'b0, 1'b0, 32'h104); idle(); tick();
        // Train 0x10 -> 0x40 taken, then fetch it
        ex(32'h104, 1'b0, 1'b0, 32'h108); drv(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h40, 1'b1); tick();
        ex(32'h108, 1'b0, 1'b0, 32'h10C); drv(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0); tick();
        ex(32'h10, 1'b1, 1'b1, 32'h40);   idle(); tick();
        ex(32'h40, 1'b0, 1'b0, 32'h44);   drv(1'b0, 1'b1, 32'h10, 1'b1, 32'h10, 32'h40, 1'b0); tick();
        // ctr now 01; hold on 0x10 and walk the counter, lookup sees pre-update value
        ex(32'h10, 1'b1, 1'b0, 32'h14);   drv(1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 32'h40, 1'b1); tick();
        ex(32'h10, 1'b1, 1'b1, 32'h40);   tick();
        ex(32'h10, 1'b1, 1'b1, 32'h40);   tick();
        ex(32'h10, 1'b1, 1'b1, 32'h40);   drv(1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 32'h40, 1'b0); tick();
        ex(32'h10, 1'b1, 1'b1, 32'h40);   tick();
        ex(32'h10, 1'b1, 1'b0, 32'h14);   tick();
        ex(32'h10, 1'b1, 1'b0, 32'h14);   tick();
        ex(32'h10, 1'b1, 1'b0, 32'h14);   drv(1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 32'h40, 1'b1); tick();
        ex(32'h10, 1'b1, 1'b0, 32'h14);   tick();
        // ctr back to 10; alias 0x50 shares the index
        ex(32'h10, 1'b1, 1'b1, 32'h40);   drv(1'b0, 1'b1, 32'h50, 1'b0, 32'h0, 32'h0, 1'b0); tick();
        ex(32'h50, 1'b0, 1'b0, 32'h54);   drv(1'b0, 1'b1, 32'h10, 1'b1, 32'h50, 32'h90, 1'b0); tick();
        ex(32'h10, 1'b1, 1'b1, 32'h40);   drv(1'b0, 1'b1, 32'h10, 1'b1, 32'h50, 32'h80, 1'b1); tick();
        ex(32'h10, 1'b0, 1'b0, 32'h14);   drv(1'b0, 1'b1, 32'h50, 1'b0, 32'h0, 32'h0, 1'b0); tick();
        ex(32'h50, 1'b1, 1'b1, 32'h80);   drv(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 1'b0); tick();
        // +4 wraps to zero
        ex(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0); idle(); tick();
        // Mid-run reset drops same-cycle redirect and update, clears the BTB
        ex(32'h0, 1'b0, 1'b0, 32'h4);     reset = 1'b1; drv(1'b0, 1'b1, 32'h200, 1'b1, 32'h0, 32'h300, 1'b1); tick();
        ex(32'h0, 1'b0, 1'b0, 32'h4);     reset = 1'b0; drv(1'b0, 1'b1, 32'h50, 1'b0, 32'h0, 32'h0, 1'b0); tick();
        ex(32'h50, 1'b0, 1'b0, 32'h54);   drv(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0); tick();
        ex(32'h0, 1'b0, 1'b0, 32'h4);     idle(); tick();
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
